// File: rtl/axi_slv_pkg.sv
// Shared types and helpers for the axi_sram_slave AXI3 responder.
package axi_slv_pkg;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Address of the next beat; WRAP and the reserved encoding behave as INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        logic [31:0] nxt;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_INCR:  nxt = addr + 32'd4;
            BURST_WRAP:  nxt = addr + 32'd4;
            default:     nxt = addr + 32'd4;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi_slv_mem.sv
// Dual-port word SRAM: one synchronous read port, one byte-enable write port.
// A read and write to the same word on the same edge returns the old data.
module axi_slv_mem #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read port; the output register holds its value while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by on-chip SRAM with independent read and write FSMs.
// Optional feature macro: AXI_SLV_DECERR_EN (out-of-range beats answer DECERR).
module axi_sram_slave
    import axi_slv_pkg::*;
#(
    parameter int unsigned MEM_WORDS_LOG2 = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

`ifdef AXI_SLV_DECERR_EN
    localparam logic DECERR_EN = 1'b1;
`else
    localparam logic DECERR_EN = 1'b0;
`endif

    localparam int unsigned AW = MEM_WORDS_LOG2;

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic out_of_range(input logic [31:0] a);
        return DECERR_EN && (((a - BASE_ADDR) >> (AW + 2)) != 32'd0);
    endfunction

    logic unused_ok;
    assign unused_ok = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot, wid};

    // Read side state
    r_state_e    r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] raddr_q, raddr_d;
    logic [3:0]  rlen_q, rlen_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic        rdec_q, rdec_d;
    logic        mem_re;
    logic [AW-1:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [31:0] r_nxt;

    // Write side state
    w_state_e    w_state_q, w_state_d;
    logic        awready_q, awready_d;
    logic [3:0]  bid_q, bid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [3:0]  wlen_q, wlen_d;
    logic [1:0]  wburst_q, wburst_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        wover_q, wover_d;
    logic        wdec_q, wdec_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        w_beat_dec;
    logic        mem_we;

    assign rvalid  = (r_state_q == R_DATA);
    assign arready = arready_q;
    assign rid     = rid_q;
    assign rlast   = rvalid && (rcnt_q == rlen_q);
    assign rresp   = (rvalid && rdec_q) ? RESP_DECERR : RESP_OKAY;
    assign rdata   = (rvalid && !rdec_q) ? mem_rdata : '0;

    assign awready = awready_q;
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = bid_q;
    assign bresp   = bresp_q;

    // Read FSM next state; the SRAM is read one beat ahead so rdata is ready with rvalid.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rdec_d    = rdec_q;
        mem_re    = 1'b0;
        mem_raddr = word_idx(raddr_q);
        r_nxt     = next_addr(raddr_q, rburst_q);
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rid_d     = arid;
                    raddr_d   = araddr;
                    rlen_d    = arlen;
                    rburst_d  = arburst;
                    rcnt_d    = '0;
                    rdec_d    = out_of_range(araddr);
                    mem_re    = 1'b1;
                    mem_raddr = word_idx(araddr);
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rcnt_q == rlen_q) begin
                        r_state_d = R_IDLE;
                        arready_d = 1'b1;
                    end else begin
                        raddr_d   = r_nxt;
                        rcnt_d    = rcnt_q + 4'd1;
                        rdec_d    = out_of_range(r_nxt);
                        mem_re    = 1'b1;
                        mem_raddr = word_idx(r_nxt);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write FSM next state; response codes are resolved on the wlast beat.
    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        bid_d      = bid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        wcnt_d     = wcnt_q;
        wover_d    = wover_q;
        wdec_d     = wdec_q;
        bresp_d    = bresp_q;
        w_beat_dec = out_of_range(waddr_q);
        mem_we     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    w_state_d = W_DATA;
                    awready_d = 1'b0;
                    bid_d     = awid;
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wburst_d  = awburst;
                    wcnt_d    = '0;
                    wover_d   = 1'b0;
                    wdec_d    = 1'b0;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_we  = !w_beat_dec;
                    waddr_d = next_addr(waddr_q, wburst_q);
                    if (wlast) begin
                        w_state_d = W_RESP;
                        if (wdec_q || w_beat_dec) begin
                            bresp_d = RESP_DECERR;
                        end else if (wover_q || (wcnt_q != wlen_q)) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            bresp_d = RESP_OKAY;
                        end
                    end else begin
                        // Sticky overrun flag covers bursts longer than the 4-bit counter.
                        wcnt_d = wcnt_q + 4'd1;
                        wdec_d = wdec_q || w_beat_dec;
                        if (wcnt_q == wlen_q) begin
                            wover_d = 1'b1;
                        end
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    awready_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read-side registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rdec_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rdec_q    <= rdec_d;
        end
    end

    // Write-side registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            wover_q   <= 1'b0;
            wdec_q    <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            bid_q     <= bid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            wover_q   <= wover_d;
            wdec_q    <= wdec_d;
            bresp_q   <= bresp_d;
        end
    end

    axi_slv_mem #(
        .ADDR_W(AW)
    ) u_mem (
        .clk   (aclk),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata),
        .we    (mem_we && (w_state_q == W_DATA)),
        .waddr (word_idx(waddr_q)),
        .wdata (wdata),
        .wstrb (wstrb)
    );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_sram_slave #(
        .MEM_WORDS_LOG2(16),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    logic [3:0]  rd_id [16];
    int          rd_cyc [16];
    logic [31:0] hold_data [16];
    logic        hold_last [16];
    bit          held [16];
    int          rd_arready_bad;
    logic [1:0]  wr_resp;
    logic [3:0]  wr_bid;
    int          bhold_bad;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input int nbeats, input int bdelay, output bit ok);
        int t;
        ok = 1'b1;
        bhold_bad = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (awready !== 1'b1 && t < 50) begin tick(); t++; end
        if (awready !== 1'b1) ok = 1'b0;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            t = 0;
            while (wready !== 1'b1 && t < 50) begin tick(); t++; end
            if (wready !== 1'b1) ok = 1'b0;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (bvalid !== 1'b1 && t < 50) begin tick(); t++; end
        if (bvalid !== 1'b1) ok = 1'b0;
        wr_resp = bresp;
        wr_bid = bid;
        for (int i = 0; i < bdelay; i++) begin
            tick();
            if (bvalid !== 1'b1 || awready !== 1'b0 || bresp !== wr_resp || bid !== wr_bid) bhold_bad++;
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input bit stall, output bit ok);
        int t, n, cyc;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        rd_arready_bad = 0;
        for (int i = 0; i < 16; i++) held[i] = 1'b0;
        t = 0;
        while (arready !== 1'b1 && t < 50) begin tick(); t++; end
        tick();
        arvalid = 1'b0;
        n = 0;
        cyc = 0;
        while (n <= int'(len) && cyc < 100) begin
            rready = stall ? ((cyc % 2) == 0) : 1'b1;
            if (arready !== 1'b0) rd_arready_bad++;
            if (rvalid === 1'b1) begin
                if (rready) begin
                    rd_data[n] = rdata; rd_last[n] = rlast; rd_resp[n] = rresp;
                    rd_id[n] = rid; rd_cyc[n] = cyc;
                    n++;
                end else begin
                    hold_data[n] = rdata; hold_last[n] = rlast; held[n] = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        ok = (n == int'(len) + 1);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        tests++;
        if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 000000", {arready, awready, wready, rvalid, bvalid, rlast});
        end
        tests++;
        if ({rid, bid, rresp, bresp, rdata} !== 44'h0) begin
            fails++;
            $display("FAIL reset_data: got rid=%h bid=%h rresp=%h bresp=%h rdata=%h expected all 0",
                     rid, bid, rresp, bresp, rdata);
        end
        aresetn = 1'b1;
        tick();
        tests++;
        if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got arready=%b awready=%b wready=%b expected 1 1 0", arready, awready, wready);
        end
    endtask

    task automatic test_incr();
        bit ok;
        for (int i = 0; i < 8; i++) begin wbuf[i] = i; sbuf[i] = 4'hF; end
        do_write(32'h100, 4'd7, 2'b01, 4'd9, 8, 0, ok);
        tests++;
        if (!ok || wr_resp !== 2'b00 || wr_bid !== 4'd9) begin
            fails++;
            $display("FAIL incr_write: ok=%0d bresp=%h bid=%h expected ok=1 bresp=0 bid=9", ok, wr_resp, wr_bid);
        end
        do_read(32'h100, 4'd7, 2'b01, 4'd5, 1'b0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL incr_read_timeout: beats missing, expected 8"); end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (rd_data[k] !== 32'(k) || rd_last[k] !== (k == 7) || rd_id[k] !== 4'd5 ||
                rd_resp[k] !== 2'b00 || rd_cyc[k] !== k) begin
                fails++;
                $display("FAIL incr_beat%0d: data=%h last=%b id=%h resp=%h cyc=%0d expected data=%h last=%b id=5 resp=0 cyc=%0d",
                         k, rd_data[k], rd_last[k], rd_id[k], rd_resp[k], rd_cyc[k], k, (k == 7), k);
            end
        end
        tests++;
        if (rd_arready_bad != 0 || arready !== 1'b1) begin
            fails++;
            $display("FAIL incr_arready: busy_high=%0d after=%b expected 0 and 1", rd_arready_bad, arready);
        end
    endtask

    task automatic test_strobe();
        bit ok;
        wbuf[0] = 32'h1122_3344; sbuf[0] = 4'hF;
        do_write(32'h200, 4'd0, 2'b01, 4'd1, 1, 0, ok);
        wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'b0101;
        do_write(32'h200, 4'd0, 2'b01, 4'd1, 1, 0, ok);
        do_read(32'h200, 4'd0, 2'b01, 4'd2, 1'b0, ok);
        tests++;
        if (!ok || rd_data[0] !== 32'h11BB_33DD || rd_last[0] !== 1'b1) begin
            fails++;
            $display("FAIL strobe: ok=%0d data=%h last=%b expected 11bb33dd 1", ok, rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_read(32'h100, 4'd3, 2'b01, 4'd7, 1'b1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_read_timeout: beats missing, expected 4"); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (rd_data[k] !== 32'(k) || rd_last[k] !== (k == 3) ||
                (held[k] && (hold_data[k] !== rd_data[k] || hold_last[k] !== rd_last[k]))) begin
                fails++;
                $display("FAIL bp_beat%0d: data=%h last=%b held=%0d hold=%h/%b expected data=%h last=%b",
                         k, rd_data[k], rd_last[k], held[k], hold_data[k], hold_last[k], k, (k == 3));
            end
        end
        tests++;
        if (!held[1] || !held[3]) begin
            fails++;
            $display("FAIL bp_stalls: stalled beats seen=%b%b expected 11", held[1], held[3]);
        end
        wbuf[0] = 32'h0300_0300; sbuf[0] = 4'hF;
        do_write(32'h300, 4'd0, 2'b01, 4'd6, 1, 5, ok);
        tests++;
        if (!ok || bhold_bad != 0 || wr_resp !== 2'b00 || wr_bid !== 4'd6) begin
            fails++;
            $display("FAIL bp_bready: ok=%0d bad_cycles=%0d bresp=%h bid=%h expected 1 0 0 6", ok, bhold_bad, wr_resp, wr_bid);
        end
    endtask

    task automatic test_concurrent();
        bit ok;
        wbuf[0] = 32'hCAFE_0001; sbuf[0] = 4'hF;
        do_write(32'h400, 4'd0, 2'b01, 4'd0, 1, 0, ok);
        arid = 4'd3; araddr = 32'h400; arlen = 4'd0; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'd4; awaddr = 32'h400; awlen = 4'd0; awburst = 2'b01; awvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0;
        wdata = 32'hBEEF_0002; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
        tests++;
        if (rvalid !== 1'b1 || wready !== 1'b1 || rdata !== 32'hCAFE_0001 || rid !== 4'd3) begin
            fails++;
            $display("FAIL conc_start: rvalid=%b wready=%b rdata=%h rid=%h expected 1 1 cafe0001 3", rvalid, wready, rdata, rid);
        end
        tick();
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
        tests++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== 4'd4 || rvalid !== 1'b0) begin
            fails++;
            $display("FAIL conc_b: bvalid=%b bresp=%h bid=%h rvalid=%b expected 1 0 4 0", bvalid, bresp, bid, rvalid);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        // AR handshake and W beat on the same edge to the same word
        awaddr = 32'h400; awlen = 4'd0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        araddr = 32'h400; arlen = 4'd0; arvalid = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 32'hBEEF_0002) begin
            fails++;
            $display("FAIL conc_read_first: rvalid=%b rdata=%h expected 1 beef0002", rvalid, rdata);
        end
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        tick();
        do_read(32'h400, 4'd0, 2'b01, 4'd3, 1'b0, ok);
        tests++;
        if (!ok || rd_data[0] !== 32'h1234_5678) begin
            fails++;
            $display("FAIL conc_after: ok=%0d data=%h expected 12345678", ok, rd_data[0]);
        end
    endtask

    task automatic test_len_mismatch();
        bit ok;
        wbuf[0] = 32'h5555_5555; sbuf[0] = 4'hF;
        do_write(32'h508, 4'd0, 2'b01, 4'd0, 1, 0, ok);
        wbuf[0] = 32'hA0A0_0000; wbuf[1] = 32'hB0B0_0001; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(32'h500, 4'd3, 2'b01, 4'd2, 2, 0, ok);
        tests++;
        if (!ok || wr_resp !== 2'b10) begin
            fails++;
            $display("FAIL len_mismatch_resp: ok=%0d bresp=%h expected 2", ok, wr_resp);
        end
        do_read(32'h500, 4'd2, 2'b01, 4'd0, 1'b0, ok);
        tests++;
        if (!ok || rd_data[0] !== 32'hA0A0_0000 || rd_data[1] !== 32'hB0B0_0001 || rd_data[2] !== 32'h5555_5555) begin
            fails++;
            $display("FAIL len_mismatch_data: %h %h %h expected a0a00000 b0b00001 55555555", rd_data[0], rd_data[1], rd_data[2]);
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        wbuf[0] = 32'hDEAD_0000; wbuf[1] = 32'hDEAD_0001; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(32'h0, 4'd1, 2'b01, 4'd0, 2, 0, ok);
        do_read(32'h0004_0000, 4'd1, 2'b01, 4'd8, 1'b0, ok);
`ifdef AXI_SLV_DECERR_EN
        tests++;
        if (!ok || rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0 || rd_resp[0] !== 2'b11 || rd_resp[1] !== 2'b11) begin
            fails++;
            $display("FAIL oor_read: data=%h %h resp=%h %h expected 0 0 3 3", rd_data[0], rd_data[1], rd_resp[0], rd_resp[1]);
        end
`else
        tests++;
        if (!ok || rd_data[0] !== 32'hDEAD_0000 || rd_data[1] !== 32'hDEAD_0001 || rd_resp[0] !== 2'b00 || rd_resp[1] !== 2'b00) begin
            fails++;
            $display("FAIL oor_wrap: data=%h %h resp=%h %h expected dead0000 dead0001 0 0", rd_data[0], rd_data[1], rd_resp[0], rd_resp[1]);
        end
`endif
    endtask

    task automatic test_reset_midburst();
        bit ok;
        int t;
        arid = 4'd1; araddr = 32'h100; arlen = 4'd7; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
        t = 0;
        while (arready !== 1'b1 && t < 50) begin tick(); t++; end
        tick();
        arvalid = 1'b0;
        tick();
        tests++;
        if (rvalid !== 1'b1 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL mid_pre: rvalid=%b rdata=%h expected 1 0", rvalid, rdata);
        end
        aresetn = 1'b0;
        #1;
        tests++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b0 || rlast !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: rvalid=%b bvalid=%b arready=%b rlast=%b expected 0 0 0 0", rvalid, bvalid, arready, rlast);
        end
        tick();
        aresetn = 1'b1;
        tick();
        do_read(32'h100, 4'd7, 2'b01, 4'd2, 1'b0, ok);
        tests++;
        if (!ok || rd_data[0] !== 32'h0 || rd_data[5] !== 32'h5 || rd_data[7] !== 32'h7) begin
            fails++;
            $display("FAIL mid_retain: ok=%0d data0=%h data5=%h data7=%h expected 0 5 7", ok, rd_data[0], rd_data[5], rd_data[7]);
        end
    endtask

    initial begin
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        test_reset();
        test_incr();
        test_strobe();
        test_backpressure();
        test_concurrent();
        test_len_mismatch();
        test_out_of_range();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
